// File: rtl/wb_writeback_queue_if.sv
// rtl/wb_writeback_queue_if.sv - MEM-side entry, register-file port and forwarding bundle
interface wb_writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int RA_W  = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_we;
  logic [RA_W-1:0]           in_rd;
  logic [5:0]                in_op;
  logic [31:0]               in_pc;
  logic [31:0]               in_imm;
  logic [31:0]               in_alu;
  logic [1:0]                in_daddr;
  logic [31:0]               in_drdata;
  logic                      rf_grant;
  logic                      rf_we;
  logic [RA_W-1:0]           rf_waddr;
  logic [31:0]               rf_wdata;
  logic [RA_W-1:0]           fwd_raddr;
  logic                      fwd_hit;
  logic [31:0]               fwd_data;
  logic                      misalign_err;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output in_valid, in_we, in_rd, in_op, in_pc, in_imm, in_alu, in_daddr, in_drdata,
           rf_grant, fwd_raddr,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, misalign_err, count
  );

  modport slave (
    input  in_valid, in_we, in_rd, in_op, in_pc, in_imm, in_alu, in_daddr, in_drdata,
           rf_grant, fwd_raddr,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, misalign_err, count
  );
endinterface

// File: rtl/wb_writeback_queue.sv
// rtl/wb_writeback_queue.sv - writeback formatting, FIFO to register-file port, forwarding lookup
module wb_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int RA_W   = 5,
  parameter int PC_INC = 4
) (
  input logic               clk,
  input logic               rst,
  wb_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [5:0] OP_PCREL = 6'b000001;
  localparam logic [5:0] OP_LINK0 = 6'b000010;
  localparam logic [5:0] OP_LINK1 = 6'b000011;
  localparam logic [5:0] OP_LB    = 6'b001010;
  localparam logic [5:0] OP_LH    = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b001100;
  localparam logic [5:0] OP_LBU   = 6'b001101;
  localparam logic [5:0] OP_LHU   = 6'b001110;

  logic [RA_W-1:0] q_rd   [DEPTH];
  logic [31:0]     q_data [DEPTH];
  logic [PW-1:0]   head, tail, fidx;
  logic [CW-1:0]   cnt;

  logic            rf_we_q;
  logic [RA_W-1:0] rf_waddr_q;
  logic [31:0]     rf_wdata_q;
  logic            err_q;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     wb_val;
  logic            misaligned, accept, push, pop;
  logic            fwd_hit_c;
  logic [31:0]     fwd_data_c;

  always_comb begin
    ld_byte = '0;
    case (bus.in_daddr)
      2'd0: ld_byte = bus.in_drdata[7:0];
      2'd1: ld_byte = bus.in_drdata[15:8];
      2'd2: ld_byte = bus.in_drdata[23:16];
      default: ld_byte = bus.in_drdata[31:24];
    endcase
    ld_half = bus.in_daddr[1] ? bus.in_drdata[31:16] : bus.in_drdata[15:0];

    wb_val = bus.in_alu;
    case (bus.in_op)
      OP_PCREL:           wb_val = bus.in_pc + bus.in_imm;
      OP_LINK0, OP_LINK1: wb_val = bus.in_pc + 32'(PC_INC);
      OP_LB:              wb_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:             wb_val = {24'd0, ld_byte};
      OP_LH:              wb_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:             wb_val = {16'd0, ld_half};
      OP_LW:              wb_val = bus.in_drdata;
      default:            wb_val = bus.in_alu;
    endcase
  end

  assign misaligned = ((bus.in_op == OP_LH) || (bus.in_op == OP_LHU)) && bus.in_daddr[0];
  assign accept     = bus.in_valid && bus.in_ready;
  // Non-writing and x0 destinations are consumed here so they never occupy a slot
  assign push       = accept && bus.in_we && (bus.in_rd != '0) && !misaligned;
  assign pop        = (cnt != '0) && bus.rf_grant;

  assign bus.in_ready     = (cnt < CW'(DEPTH));
  assign bus.count        = cnt;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.misalign_err = err_q;
  assign bus.fwd_hit      = fwd_hit_c;
  assign bus.fwd_data     = fwd_data_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= accept && misaligned;
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head       <= head + 1'b1;
        rf_we_q    <= 1'b1;
        rf_waddr_q <= q_rd[head];
        rf_wdata_q <= q_data[head];
      end else begin
        rf_we_q <= 1'b0;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_rd[tail]   <= bus.in_rd;
      q_data[tail] <= wb_val;
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest one
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fidx       = '0;
    if (rf_we_q && (rf_waddr_q == bus.fwd_raddr)) begin
      fwd_hit_c  = 1'b1;
      fwd_data_c = rf_wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fidx = head + PW'(i);
      if ((CW'(i) < cnt) && (q_rd[fidx] == bus.fwd_raddr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = q_data[fidx];
      end
    end
    if (bus.fwd_raddr == '0) begin
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
    end
  end
endmodule

// File: tb/tb_wb_writeback_queue.sv
// tb/tb_wb_writeback_queue.sv - directed bench with queue-based reference model
module tb_wb_writeback_queue;
  localparam int DEPTH  = 4;
  localparam int RA_W   = 5;
  localparam int PC_INC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_writeback_queue_if #(.DEPTH(DEPTH), .RA_W(RA_W)) bus ();

  wb_writeback_queue #(.DEPTH(DEPTH), .RA_W(RA_W), .PC_INC(PC_INC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [RA_W-1:0] rd;
    logic [31:0]     data;
  } ent_t;

  ent_t            mq[$];
  logic            m_rf_we;
  logic [RA_W-1:0] m_waddr;
  logic [31:0]     m_wdata;
  logic            m_err;

  function automatic logic [31:0] fmt(input logic [5:0] op, input logic [31:0] pc, imm, alu,
                                      input logic [1:0] da, input logic [31:0] dr);
    logic [31:0] b, h;
    b = dr >> (8 * da);
    h = dr >> (16 * da[1]);
    case (op)
      6'd1:        return pc + imm;
      6'd2, 6'd3:  return pc + PC_INC;
      6'd10:       return 32'($signed(b[7:0]));
      6'd13:       return {24'd0, b[7:0]};
      6'd11:       return 32'($signed(h[15:0]));
      6'd14:       return {16'd0, h[15:0]};
      6'd12:       return dr;
      default:     return alu;
    endcase
  endfunction

  always @(posedge clk) begin
    bit ready, bad;
    if (rst) begin
      mq.delete();
      m_rf_we = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_err   = 1'b0;
    end else begin
      ready = (mq.size() < DEPTH);
      bad   = ((bus.in_op == 6'd11) || (bus.in_op == 6'd14)) && bus.in_daddr[0];
      m_err = bus.in_valid && ready && bad;
      if (mq.size() > 0 && bus.rf_grant) begin
        m_rf_we = 1'b1;
        m_waddr = mq[0].rd;
        m_wdata = mq[0].data;
        void'(mq.pop_front());
      end else begin
        m_rf_we = 1'b0;
      end
      if (bus.in_valid && ready && !bad && bus.in_we && bus.in_rd != 0)
        mq.push_back('{rd: bus.in_rd,
                       data: fmt(bus.in_op, bus.in_pc, bus.in_imm, bus.in_alu,
                                 bus.in_daddr, bus.in_drdata)});
    end
  end

  always @(negedge clk) begin
    bit          hit;
    logic [31:0] dat;
    if (chk_en && !rst) begin
      hit = 1'b0;
      dat = '0;
      if (bus.fwd_raddr != 0) begin
        for (int i = mq.size() - 1; i >= 0 && !hit; i--)
          if (mq[i].rd == bus.fwd_raddr) begin
            hit = 1'b1;
            dat = mq[i].data;
          end
        if (!hit && m_rf_we && m_waddr == bus.fwd_raddr) begin
          hit = 1'b1;
          dat = m_wdata;
        end
      end
      chk("cyc_in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      chk("cyc_count", 32'(bus.count), 32'(mq.size()));
      chk("cyc_rf_we", 32'(bus.rf_we), 32'(m_rf_we));
      chk("cyc_rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
      chk("cyc_rf_wdata", bus.rf_wdata, m_wdata);
      chk("cyc_misalign", 32'(bus.misalign_err), 32'(m_err));
      chk("cyc_fwd_hit", 32'(bus.fwd_hit), 32'(hit));
      chk("cyc_fwd_data", bus.fwd_data, dat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] pc, imm, alu,
                      input logic [1:0] da, input logic [31:0] dr, input logic we);
    bus.in_op     = op;
    bus.in_rd     = rd;
    bus.in_pc     = pc;
    bus.in_imm    = imm;
    bus.in_alu    = alu;
    bus.in_daddr  = da;
    bus.in_drdata = dr;
    bus.in_we     = we;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic expect_write(input string name, input logic [4:0] rd, input logic [31:0] data,
                              output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!bus.rf_we && waited < 10);
    chk({name, "_we"}, 32'(bus.rf_we), 32'd1);
    chk({name, "_addr"}, 32'(bus.rf_waddr), 32'(rd));
    chk({name, "_data"}, bus.rf_wdata, data);
    tick();
    chk({name, "_single"}, 32'(bus.rf_we), 32'd0);
  endtask

  initial begin
    int w;
    bus.in_valid = 0; bus.in_we = 0; bus.in_rd = 0; bus.in_op = 0; bus.in_pc = 0;
    bus.in_imm = 0; bus.in_alu = 0; bus.in_daddr = 0; bus.in_drdata = 0;
    bus.rf_grant = 0; bus.fwd_raddr = 0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_misalign", 32'(bus.misalign_err), 32'd0);

    bus.rf_grant = 1'b1;
    send(6'b001010, 5'd3, 0, 0, 0, 2'b11, 32'h80FF_1234, 1'b1);
    chk("model_lb", fmt(6'b001010, 0, 0, 0, 2'b11, 32'h80FF_1234), 32'hFFFF_FF80);
    expect_write("lb", 5'd3, 32'hFFFF_FF80, w);
    chk("lb_latency", 32'(w), 32'd1);
    send(6'b001101, 5'd3, 0, 0, 0, 2'b11, 32'h80FF_1234, 1'b1);
    expect_write("lbu", 5'd3, 32'h0000_0080, w);

    send(6'b001011, 5'd4, 0, 0, 0, 2'b01, 32'h1234_5678, 1'b1);
    chk("lh_mis_err", 32'(bus.misalign_err), 32'd1);
    chk("lh_mis_count", 32'(bus.count), 32'd0);
    tick();
    chk("lh_mis_pulse", 32'(bus.misalign_err), 32'd0);
    chk("lh_mis_nowr", 32'(bus.rf_we), 32'd0);
    send(6'b001110, 5'd5, 0, 0, 0, 2'b10, 32'hBEEF_0000, 1'b1);
    expect_write("lhu", 5'd5, 32'h0000_BEEF, w);

    send(6'b000010, 5'd6, 32'h0000_0100, 0, 0, 0, 0, 1'b1);
    expect_write("link", 5'd6, 32'h0000_0104, w);
    send(6'b000001, 5'd6, 32'hFFFF_FFFC, 32'd8, 0, 0, 0, 1'b1);
    chk("model_pcrel", fmt(6'b000001, 32'hFFFF_FFFC, 32'd8, 0, 0, 0), 32'h0000_0004);
    expect_write("pcrel", 5'd6, 32'h0000_0004, w);
    send(6'b001100, 5'd2, 0, 0, 0, 0, 32'h1234_5678, 1'b1);
    expect_write("lw", 5'd2, 32'h1234_5678, w);

    bus.rf_grant = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(6'b000000, 5'(10 + i), 0, 0, 32'hA0 + 32'(i), 0, 0, 1'b1);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_count", 32'(bus.count), 32'd4);
    bus.in_rd = 5'd14; bus.in_alu = 32'hA4; bus.in_valid = 1'b1;
    bus.rf_grant = 1'b1;
    tick();
    chk("drain0_addr", 32'(bus.rf_waddr), 32'd10);
    chk("drain0_count", 32'(bus.count), 32'd3);
    chk("drain0_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("drain1_addr", 32'(bus.rf_waddr), 32'd11);
    chk("drain1_count", 32'(bus.count), 32'd3);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("drain_we", 32'(bus.rf_we), 32'd1);
      chk("drain_addr", 32'(bus.rf_waddr), 32'(10 + i));
      chk("drain_data", bus.rf_wdata, 32'hA0 + 32'(i));
    end
    tick();
    chk("drain_done", 32'(bus.rf_we), 32'd0);

    bus.rf_grant = 1'b0;
    send(6'b000000, 5'd7, 0, 0, 32'h11, 0, 0, 1'b1);
    send(6'b000000, 5'd7, 0, 0, 32'h22, 0, 0, 1'b1);
    bus.fwd_raddr = 5'd7;
    #1;
    chk("fwd7_hit", 32'(bus.fwd_hit), 32'd1);
    chk("fwd7_data", bus.fwd_data, 32'h22);
    bus.fwd_raddr = 5'd0;
    #1;
    chk("fwd0_hit", 32'(bus.fwd_hit), 32'd0);
    bus.fwd_raddr = 5'd9;
    #1;
    chk("fwd9_hit", 32'(bus.fwd_hit), 32'd0);
    chk("fwd9_data", bus.fwd_data, 32'd0);
    tick();

    send(6'b000000, 5'd8, 0, 0, 32'h33, 0, 0, 1'b1);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    rst = 1'b1;
    bus.in_rd = 5'd9; bus.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.rf_grant = 1'b1;
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_nowr", 32'(bus.rf_we), 32'd0);
    end

    send(6'b000000, 5'd0, 0, 0, 32'h55, 0, 0, 1'b1);
    chk("rd0_count", 32'(bus.count), 32'd0);
    send(6'b000000, 5'd12, 0, 0, 32'h66, 0, 0, 1'b0);
    chk("we0_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_nowr", 32'(bus.rf_we), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
